ctrl_pipe_hazard: RTL and testbench
===================================

# ctrl_pipe_hazard

Consumes the 10-bit control word and jump flag produced by the ID-stage decoder, then carries the control bits through the ID/EX, EX/MEM and MEM/WB pipeline registers. Each stage sees its own unpacked control signals. The block also handles load-use stalls, branch and jump flushes, write-register selection, and EX-stage forwarding selects. It sits between the decoder and the datapath stage registers of the 5-stage pipeline.

## Interface
Parameters:
- REG_W, 5, register-number width
- CTRL_W, 10, control word width; bit layout {RegDst[9], ALUSrc[8], ALUOp[7:6], Branch[5], MemRead[4], MemWrite[3], MemtoReg[2], RegWrite[1], Jal[0]}

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_control  in  10  decoder control word for the instruction in ID
- id_jump  in  1  decoder Jump flag (J/JAL)
- id_rs, id_rt, id_rd  in  5 each  register fields of the ID instruction
- ex_zero  in  1  ALU zero flag of the instruction in EX
- ex_regdst_alusrc  out  2  {RegDst, ALUSrc} of the EX instruction
- ex_aluop  out  2  ALUOp of the EX instruction
- ex_wreg  out  5  selected destination of the EX instruction
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- mem_memread, mem_memwrite  out  1 each  data-memory controls
- wb_memtoreg, wb_regwrite, wb_jal  out  1 each  write-back controls
- wb_wreg  out  5  write-back register number
- pc_write, ifid_write  out  1 each  0 holds PC / IF-ID register
- ifid_flush  out  1  zero the IF/ID instruction
- pc_src_branch  out  1  taken branch; PC loads branch target

## Operation
- ID/EX captures id_control, id_rs, id_rt, id_rd. On a stall or branch flush it captures a bubble: all 10 bits 0 and register fields 0.
- The EX destination is combinational from ID/EX:
  - Jal=1 selects 31.
  - Otherwise RegDst=1 selects rd.
  - Otherwise it selects rt.
- EX/MEM captures Branch, MemRead, MemWrite, MemtoReg, RegWrite, Jal, ex_wreg and ex_zero. On a branch flush it captures all 0.
- MEM/WB captures MemtoReg, RegWrite, Jal and wreg from EX/MEM unconditionally.
- Source usage in ID:
  - uses_rs = ~id_jump.
  - uses_rt = MemWrite | Branch | (RegDst & ~ALUSrc & ~Jal).
  - The OR terms must resolve the decoder's don't-care RegDst on SW to 1.
- Load-use stall occurs when all of the following hold:
  - ID/EX MemRead=1;
  - ex_wreg≠0;
  - ex_wreg matches id_rs (with uses_rs) or id_rt (with uses_rt).
- During a stall: pc_write=0, ifid_write=0, and a bubble enters ID/EX.
- Branch is resolved in MEM: pc_src_branch = mem Branch & mem zero. When taken, a bubble is loaded into IF/ID (ifid_flush=1), ID/EX and EX/MEM.
- Jump is resolved in ID: id_jump=1 asserts ifid_flush. The jump itself proceeds into ID/EX; JAL writes r31.
- Priority is taken branch > load-use stall > jump. When a branch is taken, stall is suppressed (pc_write=1, ifid_write=1) and the ID jump is discarded.
- Forwarding for operand A:
  - fwd_a=10 if EX/MEM RegWrite and EX/MEM wreg≠0 and it equals ID/EX rs.
  - Else fwd_a=01 on the same test against MEM/WB.
  - Else fwd_a=00.
- fwd_b uses the same rules against ID/EX rt. EX/MEM always wins over MEM/WB.

## Timing
- Reset: every pipeline register clears to 0. All control outputs, ex_wreg, wb_wreg, fwd_a, fwd_b and pc_src_branch are 0. pc_write and ifid_write are 1. ifid_flush is 0.
- Reset mid-operation clears all in-flight control on the next edge. No stall or flush survives reset.
- Latency from ID capture: EX outputs after 1 cycle, MEM after 2, WB after 3.
- Stall, flush and forward outputs are combinational from the current register contents and ID inputs. They are valid in the same cycle.
- A load-use stall lasts exactly 1 cycle. The next cycle ID/EX holds a bubble, so the hazard clears.
- A taken branch costs 3 bubbles.

## Structure
- Shared include ctrl_defs.vh holds the control-word bit-index constants, the fwd encodings and the link-register constant 31. The decoder and this block both use these definitions.
- One sub-module, hazard_detect, is purely combinational. It produces the stall, flush and forwarding outputs, so the pipeline registers stay in the top module.

## Test plan
- Reset: hold rst for 2 cycles with id_control=10'h282 → all MEM/WB outputs 0, pc_write=1, fwd_a=fwd_b=00.
- R-format 10'h282 with rs=1, rt=2, rd=3 → ex_wreg=3 after 1 cycle; wb_regwrite=1, wb_wreg=3 after 3 cycles.
- LW 10'h116 with rt=4 in EX, then R-format in ID reading rs=4 → one cycle of pc_write=0 and ifid_write=0, then a bubble in EX. The next cycle gives fwd_a=01.
- BEQ 10'h060 with ex_zero=1 → two cycles later pc_src_branch=1 and ifid_flush=1. The next cycle all EX and MEM controls are 0, even if a load-use hazard existed in ID.
- JAL 10'h243 with id_jump=1 → ifid_flush=1 in the same cycle; ex_wreg=31 one cycle later; wb_jal=1 three cycles later.
- Back-to-back writes to r5 (R then R), then a consumer of r5 → fwd_a=10, not 01.

Source files
------------

// File: rtl/ctrl_pipe_hazard_pkg.sv
// rtl/ctrl_pipe_hazard_pkg.sv - control-word layout, forwarding encodings and shared types
// Bit indices follow the decoder's {RegDst,ALUSrc,ALUOp,Branch,MemRead,MemWrite,MemtoReg,RegWrite,Jal} word.
package ctrl_pipe_hazard_pkg;

  localparam int C_REGDST   = 9;
  localparam int C_ALUSRC   = 8;
  localparam int C_ALUOP_HI = 7;
  localparam int C_ALUOP_LO = 6;
  localparam int C_BRANCH   = 5;
  localparam int C_MEMREAD  = 4;
  localparam int C_MEMWRITE = 3;
  localparam int C_MEMTOREG = 2;
  localparam int C_REGWRITE = 1;
  localparam int C_JAL      = 0;

  localparam int LINK_REG = 31;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEMWB   = 2'b01,
    FWD_EXMEM   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic jal;
  } wb_ctrl_t;

  // The younger producer (EX/MEM) always shadows the older one.
  function automatic fwd_sel_e fwd_select(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit) begin
      return FWD_EXMEM;
    end
    if (memwb_hit) begin
      return FWD_MEMWB;
    end
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// rtl/ctrl_pipe_hazard_if.sv - decoder-side inputs and per-stage control outputs
interface ctrl_pipe_hazard_if #(
  parameter int REG_W  = 5,
  parameter int CTRL_W = 10
);
  logic [CTRL_W-1:0] id_control;
  logic              id_jump;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              ex_zero;

  logic [1:0]        ex_regdst_alusrc;
  logic [1:0]        ex_aluop;
  logic [REG_W-1:0]  ex_wreg;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_memread;
  logic              mem_memwrite;
  logic              wb_memtoreg;
  logic              wb_regwrite;
  logic              wb_jal;
  logic [REG_W-1:0]  wb_wreg;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              pc_src_branch;

  modport master (
    output id_control, id_jump, id_rs, id_rt, id_rd, ex_zero,
    input  ex_regdst_alusrc, ex_aluop, ex_wreg, fwd_a, fwd_b,
           mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite, wb_jal, wb_wreg,
           pc_write, ifid_write, ifid_flush, pc_src_branch
  );

  modport slave (
    input  id_control, id_jump, id_rs, id_rt, id_rd, ex_zero,
    output ex_regdst_alusrc, ex_aluop, ex_wreg, fwd_a, fwd_b,
           mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite, wb_jal, wb_wreg,
           pc_write, ifid_write, ifid_flush, pc_src_branch
  );
endinterface

// File: rtl/ctrl_pipe_hazard_hazard_detect.sv
// rtl/ctrl_pipe_hazard_hazard_detect.sv - combinational load-use stall, flush and forwarding selects
module hazard_detect
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             id_regdst,
  input  logic             id_alusrc,
  input  logic             id_branch,
  input  logic             id_memwrite,
  input  logic             id_jal,
  input  logic             id_jump,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_wreg,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_wreg,
  output logic             stall,
  output logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output fwd_sel_e         fwd_a,
  output fwd_sel_e         fwd_b
);

  logic uses_rs;
  logic uses_rt;
  logic load_use;
  logic mem_valid;
  logic wb_valid;

  always_comb begin
    uses_rs = ~id_jump;
    // SW leaves RegDst as don't-care; MemWrite forces the rt dependency anyway.
    uses_rt = id_memwrite | id_branch | (id_regdst & ~id_alusrc & ~id_jal);

    load_use = ex_memread && (ex_wreg != '0) &&
               ((uses_rs && (ex_wreg == id_rs)) || (uses_rt && (ex_wreg == id_rt)));

    branch_taken = mem_branch & mem_zero;
    stall        = load_use & ~branch_taken;
    pc_write     = ~stall;
    ifid_write   = ~stall;
    ifid_flush   = branch_taken | (id_jump & ~stall);

    mem_valid = mem_regwrite && (mem_wreg != '0);
    wb_valid  = wb_regwrite && (wb_wreg != '0);
    fwd_a = fwd_select(mem_valid && (mem_wreg == ex_rs), wb_valid && (wb_wreg == ex_rs));
    fwd_b = fwd_select(mem_valid && (mem_wreg == ex_rt), wb_valid && (wb_wreg == ex_rt));
  end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// rtl/ctrl_pipe_hazard.sv - ID/EX, EX/MEM, MEM/WB control registers with hazard handling
module ctrl_pipe_hazard
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int CTRL_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  ctrl_pipe_hazard_if.slave  pif
);

  logic [CTRL_W-1:0] idex_ctrl_d, idex_ctrl_q;
  logic [REG_W-1:0]  idex_rs_d, idex_rs_q;
  logic [REG_W-1:0]  idex_rt_d, idex_rt_q;
  logic [REG_W-1:0]  idex_rd_d, idex_rd_q;

  logic              exmem_branch_d, exmem_branch_q;
  logic              exmem_memread_d, exmem_memread_q;
  logic              exmem_memwrite_d, exmem_memwrite_q;
  logic              exmem_zero_d, exmem_zero_q;
  wb_ctrl_t          exmem_wb_d, exmem_wb_q;
  logic [REG_W-1:0]  exmem_wreg_d, exmem_wreg_q;

  wb_ctrl_t          memwb_wb_d, memwb_wb_q;
  logic [REG_W-1:0]  memwb_wreg_d, memwb_wreg_q;

  logic [REG_W-1:0]  ex_wreg;
  logic              stall;
  logic              branch_taken;
  fwd_sel_e          fwd_a_sel;
  fwd_sel_e          fwd_b_sel;

  always_comb begin
    ex_wreg = idex_rt_q;
    if (idex_ctrl_q[C_JAL]) begin
      ex_wreg = REG_W'(LINK_REG);
    end else if (idex_ctrl_q[C_REGDST]) begin
      ex_wreg = idex_rd_q;
    end
  end

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_regdst    (pif.id_control[C_REGDST]),
    .id_alusrc    (pif.id_control[C_ALUSRC]),
    .id_branch    (pif.id_control[C_BRANCH]),
    .id_memwrite  (pif.id_control[C_MEMWRITE]),
    .id_jal       (pif.id_control[C_JAL]),
    .id_jump      (pif.id_jump),
    .id_rs        (pif.id_rs),
    .id_rt        (pif.id_rt),
    .ex_memread   (idex_ctrl_q[C_MEMREAD]),
    .ex_wreg      (ex_wreg),
    .ex_rs        (idex_rs_q),
    .ex_rt        (idex_rt_q),
    .mem_branch   (exmem_branch_q),
    .mem_zero     (exmem_zero_q),
    .mem_regwrite (exmem_wb_q.regwrite),
    .mem_wreg     (exmem_wreg_q),
    .wb_regwrite  (memwb_wb_q.regwrite),
    .wb_wreg      (memwb_wreg_q),
    .stall        (stall),
    .branch_taken (branch_taken),
    .pc_write     (pif.pc_write),
    .ifid_write   (pif.ifid_write),
    .ifid_flush   (pif.ifid_flush),
    .fwd_a        (fwd_a_sel),
    .fwd_b        (fwd_b_sel)
  );

  always_comb begin
    idex_ctrl_d = pif.id_control;
    idex_rs_d   = pif.id_rs;
    idex_rt_d   = pif.id_rt;
    idex_rd_d   = pif.id_rd;
    // A taken branch also discards a jump or stalled instruction sitting in ID.
    if (stall || branch_taken) begin
      idex_ctrl_d = '0;
      idex_rs_d   = '0;
      idex_rt_d   = '0;
      idex_rd_d   = '0;
    end

    exmem_branch_d   = idex_ctrl_q[C_BRANCH];
    exmem_memread_d  = idex_ctrl_q[C_MEMREAD];
    exmem_memwrite_d = idex_ctrl_q[C_MEMWRITE];
    exmem_zero_d     = pif.ex_zero;
    exmem_wb_d       = '{memtoreg: idex_ctrl_q[C_MEMTOREG],
                         regwrite: idex_ctrl_q[C_REGWRITE],
                         jal:      idex_ctrl_q[C_JAL]};
    exmem_wreg_d     = ex_wreg;
    if (branch_taken) begin
      exmem_branch_d   = 1'b0;
      exmem_memread_d  = 1'b0;
      exmem_memwrite_d = 1'b0;
      exmem_zero_d     = 1'b0;
      exmem_wb_d       = '0;
      exmem_wreg_d     = '0;
    end

    memwb_wb_d   = exmem_wb_q;
    memwb_wreg_d = exmem_wreg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ctrl_q      <= '0;
      idex_rs_q        <= '0;
      idex_rt_q        <= '0;
      idex_rd_q        <= '0;
      exmem_branch_q   <= 1'b0;
      exmem_memread_q  <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_zero_q     <= 1'b0;
      exmem_wb_q       <= '0;
      exmem_wreg_q     <= '0;
      memwb_wb_q       <= '0;
      memwb_wreg_q     <= '0;
    end else begin
      idex_ctrl_q      <= idex_ctrl_d;
      idex_rs_q        <= idex_rs_d;
      idex_rt_q        <= idex_rt_d;
      idex_rd_q        <= idex_rd_d;
      exmem_branch_q   <= exmem_branch_d;
      exmem_memread_q  <= exmem_memread_d;
      exmem_memwrite_q <= exmem_memwrite_d;
      exmem_zero_q     <= exmem_zero_d;
      exmem_wb_q       <= exmem_wb_d;
      exmem_wreg_q     <= exmem_wreg_d;
      memwb_wb_q       <= memwb_wb_d;
      memwb_wreg_q     <= memwb_wreg_d;
    end
  end

  assign pif.ex_regdst_alusrc = {idex_ctrl_q[C_REGDST], idex_ctrl_q[C_ALUSRC]};
  assign pif.ex_aluop         = idex_ctrl_q[C_ALUOP_HI:C_ALUOP_LO];
  assign pif.ex_wreg          = ex_wreg;
  assign pif.fwd_a            = fwd_a_sel;
  assign pif.fwd_b            = fwd_b_sel;
  assign pif.mem_memread      = exmem_memread_q;
  assign pif.mem_memwrite     = exmem_memwrite_q;
  assign pif.wb_memtoreg      = memwb_wb_q.memtoreg;
  assign pif.wb_regwrite      = memwb_wb_q.regwrite;
  assign pif.wb_jal           = memwb_wb_q.jal;
  assign pif.wb_wreg          = memwb_wreg_q;
  assign pif.pc_src_branch    = branch_taken;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb/tb_ctrl_pipe_hazard.sv - table-driven and scoreboard checks for ctrl_pipe_hazard
module tb_ctrl_pipe_hazard;

  localparam logic [9:0] R_OP  = 10'h282;
  localparam logic [9:0] LW_OP = 10'h116;
  localparam logic [9:0] SW_OP = 10'h108;
  localparam logic [9:0] BEQ   = 10'h060;
  localparam logic [9:0] JAL   = 10'h243;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_pipe_hazard_if #(.REG_W(5), .CTRL_W(10)) pif ();
  ctrl_pipe_hazard u_dut (.clk(clk), .rst(rst), .pif(pif));

  typedef struct {
    logic       rst;
    logic [9:0] ctl;
    logic       jmp;
    logic [4:0] rs, rt, rd;
    logic       zero;
    logic [3:0] hz;     // {pc_write, ifid_write, ifid_flush, pc_src_branch}
    logic [1:0] fa, fb;
    logic [4:0] exw;
    logic [1:0] exra, exop;
    logic [1:0] mem;    // {memread, memwrite}
    logic [2:0] wb;     // {memtoreg, regwrite, jal}
    logic [4:0] wbw;
  } vec_t;

  typedef struct {
    logic [2:0] wb;
    logic [4:0] wbw;
  } wb_exp_t;

  vec_t    vecs[$];
  vec_t    exp_q[$];
  wb_exp_t wb_q[$];
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [9:0] c, input logic j, input logic [4:0] s, t, d,
                     input logic z, input logic [3:0] hz, input logic [1:0] fa, fb,
                     input logic [4:0] exw, input logic [1:0] exra, exop, mem,
                     input logic [2:0] wb, input logic [4:0] wbw);
    vec_t v;
    v.rst = r; v.ctl = c; v.jmp = j; v.rs = s; v.rt = t; v.rd = d; v.zero = z;
    v.hz = hz; v.fa = fa; v.fb = fb; v.exw = exw; v.exra = exra; v.exop = exop;
    v.mem = mem; v.wb = wb; v.wbw = wbw;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [9:0] c, input logic j,
                       input logic [4:0] s, t, d, input logic z);
    rst = r;
    pif.id_control = c;
    pif.id_jump = j;
    pif.id_rs = s;
    pif.id_rt = t;
    pif.id_rd = d;
    pif.ex_zero = z;
  endtask

  initial begin
    drive(1'b1, 10'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    //   rst ctl    j  rs  rt  rd  z   hz       fa fb exw  exra exop mem  wb      wbw
    add(1, R_OP,  0, 1,  2,  3,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 0);
    add(1, R_OP,  0, 1,  2,  3,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 0);
    add(0, R_OP,  0, 1,  2,  3,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 0);
    add(0, 0,     0, 0,  0,  0,  0, 4'b1100, 0, 0, 3,   2,   2,   0,   3'b000, 0);
    add(0, 0,     0, 0,  0,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 0);
    add(0, 0,     0, 0,  0,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b010, 3);
    add(0, LW_OP, 0, 7,  4,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 0);
    add(0, R_OP,  0, 4,  6,  8,  0, 4'b0000, 0, 0, 4,   1,   0,   0,   3'b000, 0);
    add(0, R_OP,  0, 4,  6,  8,  0, 4'b1100, 0, 0, 0,   0,   0,   2,   3'b000, 0);
    add(0, 0,     0, 0,  0,  0,  0, 4'b1100, 1, 0, 8,   2,   2,   0,   3'b110, 4);
    add(0, BEQ,   0, 1,  2,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 0);
    add(0, LW_OP, 0, 3,  9,  0,  1, 4'b1100, 0, 0, 2,   0,   1,   0,   3'b010, 8);
    add(0, R_OP,  0, 9,  1,  10, 0, 4'b1111, 0, 0, 9,   1,   0,   0,   3'b000, 0);
    add(0, 0,     0, 0,  0,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 2);
    add(0, LW_OP, 0, 0,  5,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 0);
    add(0, JAL,   1, 5,  5,  0,  0, 4'b1110, 0, 0, 5,   1,   0,   0,   3'b000, 0);
    add(0, 0,     0, 0,  0,  0,  0, 4'b1100, 2, 2, 31,  2,   1,   2,   3'b000, 0);
    add(0, 0,     0, 0,  0,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b110, 5);
    add(0, R_OP,  0, 0,  0,  5,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b011, 31);
    add(0, R_OP,  0, 0,  0,  5,  0, 4'b1100, 0, 0, 5,   2,   2,   0,   3'b000, 0);
    add(0, R_OP,  0, 5,  5,  7,  0, 4'b1100, 0, 0, 5,   2,   2,   0,   3'b000, 0);
    add(0, 0,     0, 0,  0,  0,  0, 4'b1100, 2, 2, 7,   2,   2,   0,   3'b010, 5);
    add(1, R_OP,  0, 0,  0,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b010, 5);
    add(0, 0,     0, 0,  0,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 0);
    add(0, LW_OP, 0, 0,  6,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   0,   3'b000, 0);
    add(0, SW_OP, 0, 0,  6,  0,  0, 4'b0000, 0, 0, 6,   1,   0,   0,   3'b000, 0);
    add(0, LW_OP, 0, 0,  0,  0,  0, 4'b1100, 0, 0, 0,   0,   0,   2,   3'b000, 0);
    add(0, R_OP,  0, 0,  0,  1,  0, 4'b1100, 0, 0, 0,   1,   0,   0,   3'b110, 6);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      vec_t e;
      v = vecs[i];
      drive(v.rst, v.ctl, v.jmp, v.rs, v.rt, v.rd, v.zero);
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("row%0d hazard", i),
          {28'd0, pif.pc_write, pif.ifid_write, pif.ifid_flush, pif.pc_src_branch}, {28'd0, e.hz});
      chk($sformatf("row%0d fwd", i), {28'd0, pif.fwd_a, pif.fwd_b}, {28'd0, e.fa, e.fb});
      chk($sformatf("row%0d ex", i), {23'd0, pif.ex_regdst_alusrc, pif.ex_aluop, pif.ex_wreg},
          {23'd0, e.exra, e.exop, e.exw});
      chk($sformatf("row%0d mem", i), {30'd0, pif.mem_memread, pif.mem_memwrite}, {30'd0, e.mem});
      chk($sformatf("row%0d wb", i),
          {24'd0, pif.wb_memtoreg, pif.wb_regwrite, pif.wb_jal, pif.wb_wreg}, {24'd0, e.wb, e.wbw});
      @(posedge clk);
      #1;
    end

    // Hazard-free random stream: WB results must emerge three cycles after ID.
    for (int c = 0; c < 28; c++) begin
      if (c < 25) begin
        logic [4:0] dst;
        wb_exp_t    w;
        dst = 5'($urandom_range(1, 31));
        if ($urandom_range(0, 1) == 1) begin
          drive(1'b0, LW_OP, 1'b0, 5'd0, dst, 5'd0, 1'b0);
          w.wb = 3'b110;
        end else begin
          drive(1'b0, R_OP, 1'b0, 5'd0, 5'd0, dst, 1'b0);
          w.wb = 3'b010;
        end
        w.wbw = dst;
        wb_q.push_back(w);
      end else begin
        drive(1'b0, 10'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      end
      @(negedge clk);
      chk($sformatf("stream%0d pc_write", c), {31'd0, pif.pc_write}, 32'd1);
      if (c >= 3) begin
        wb_exp_t w;
        w = wb_q.pop_front();
        chk($sformatf("stream%0d wb", c),
            {24'd0, pif.wb_memtoreg, pif.wb_regwrite, pif.wb_jal, pif.wb_wreg}, {24'd0, w.wb, w.wbw});
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
